// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch handshake: memory request/ack on one side,
// a valid/ready instruction hand-off to decode on the other, plus branch/jump redirects.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_plus4_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        id_ready_i,
  output logic [31:0] pc_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        instr_valid_o,
  output logic        addr_err_o,
  output logic [31:0] fetch_count_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_VALID = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_pc, w_pc_nxt;
  logic [XLEN-1:0]   r_pending, w_pending_nxt;
  logic [XLEN-1:0]   r_instr, w_instr_nxt;
  logic [XLEN-1:0]   r_instr_pc, w_instr_pc_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_addr_err, w_addr_err_nxt;
  logic [XLEN-1:0]   r_fetch_count, w_fetch_count_nxt;
  logic              r_req, w_req_nxt;
  logic [XLEN-1:0]   r_addr, w_addr_nxt;
  logic              w_misaligned;
  logic [XLEN-1:0]   w_target;

  assign w_misaligned = (redirect_pc_i[1:0] != 2'b00);
  assign w_target     = w_misaligned ? EXC_VECTOR : redirect_pc_i;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_pending     <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_valid       <= 1'b0;
      r_addr_err    <= 1'b0;
      r_fetch_count <= '0;
      r_req         <= 1'b0;
      r_addr        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pending     <= w_pending_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_valid       <= w_valid_nxt;
      r_addr_err    <= w_addr_err_nxt;
      r_fetch_count <= w_fetch_count_nxt;
      r_req         <= w_req_nxt;
      r_addr        <= w_addr_nxt;
    end
  end

  // Next-state logic; redirect takes priority over the normal handshake
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pending_nxt     = r_pending;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_valid_nxt       = r_valid;
    w_addr_err_nxt    = 1'b0;
    w_fetch_count_nxt = r_fetch_count;

    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (redirect_i) begin
          w_addr_err_nxt = w_misaligned;
          w_pc_nxt       = w_target;
        end
      end
      S_REQ: begin
        if (redirect_i) begin
          w_addr_err_nxt = w_misaligned;
          if (imem_ack_i) begin
            w_pc_nxt = w_target;
          end else begin
            w_pending_nxt = w_target;
            w_state_nxt   = S_DRAIN;
          end
        end else if (imem_ack_i) begin
          w_instr_nxt    = imem_rdata_i;
          w_instr_pc_nxt = r_pc;
          w_pc_nxt       = pc_plus4_i;
          w_valid_nxt    = 1'b1;
          w_state_nxt    = S_VALID;
        end
      end
      S_VALID: begin
        if (id_ready_i) begin
          w_fetch_count_nxt = r_fetch_count + XLEN'(1);
        end
        if (redirect_i) begin
          w_addr_err_nxt = w_misaligned;
          w_valid_nxt    = 1'b0;
          w_pc_nxt       = w_target;
          w_state_nxt    = S_REQ;
        end else if (id_ready_i) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        // The in-flight response is consumed and thrown away
        if (redirect_i) begin
          w_addr_err_nxt = w_misaligned;
          w_pending_nxt  = w_target;
          if (imem_ack_i) begin
            w_pc_nxt    = w_target;
            w_state_nxt = S_REQ;
          end
        end else if (imem_ack_i) begin
          w_pc_nxt    = r_pending;
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    w_req_nxt  = (w_state_nxt == S_REQ) || (w_state_nxt == S_DRAIN);
    w_addr_nxt = w_req_nxt ? w_pc_nxt : '0;
  end

  assign pc_o          = r_pc;
  assign imem_req_o    = r_req;
  assign imem_addr_o   = r_addr;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign instr_valid_o = r_valid;
  assign addr_err_o    = r_addr_err;
  assign fetch_count_o = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with an external +4 adder and hand-computed expectations.
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_ready;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        addr_err;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  pc_fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_plus4_i    (pc_plus4),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .id_ready_i    (id_ready),
    .pc_o          (pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_valid_o (instr_valid),
    .addr_err_o    (addr_err),
    .fetch_count_o (fetch_count)
  );

  assign pc_plus4 = pc + 32'd4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_ipc"},   instr_pc, 32'h0);
    chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({tag, "_err"},   {31'd0, addr_err}, 32'd0);
    chk({tag, "_cnt"},   fetch_count, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    id_ready    = 1'b0;
    #3;
    chk_reset("rst");
    cyc();
    cyc();
    rst_n = 1'b1;

    // Dead IDLE cycle, then first request to RESET_PC
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    imem_ack   = 1'b1;
    id_ready   = 1'b1;
    imem_rdata = 32'hA000_0000;
    cyc();
    chk("req0_req", {31'd0, imem_req}, 32'd1);
    chk("req0_addr", imem_addr, 32'h0);
    chk("req0_valid", {31'd0, instr_valid}, 32'd0);
    cyc();
    chk("v0_valid", {31'd0, instr_valid}, 32'd1);
    chk("v0_ipc", instr_pc, 32'h0);
    chk("v0_instr", instr, 32'hA000_0000);
    chk("v0_req", {31'd0, imem_req}, 32'd0);
    chk("v0_pc", pc, 32'h4);
    cyc();
    chk("req1_addr", imem_addr, 32'h4);
    chk("req1_valid", {31'd0, instr_valid}, 32'd0);
    chk("req1_cnt", fetch_count, 32'd1);
    imem_rdata = 32'hA000_0004;
    cyc();
    chk("v1_ipc", instr_pc, 32'h4);
    chk("v1_instr", instr, 32'hA000_0004);
    cyc();
    chk("req2_addr", imem_addr, 32'h8);
    chk("req2_cnt", fetch_count, 32'd2);
    imem_rdata = 32'hA000_0008;
    cyc();
    chk("v2_ipc", instr_pc, 32'h8);
    chk("v2_instr", instr, 32'hA000_0008);
    cyc();
    chk("req3_cnt", fetch_count, 32'd3);
    chk("req3_addr", imem_addr, 32'hC);

    // Decode stalls for 5 cycles
    id_ready   = 1'b0;
    imem_rdata = 32'hB000_000C;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'hB000_000C);
      chk("stall_ipc", instr_pc, 32'hC);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      chk("stall_cnt", fetch_count, 32'd3);
      cyc();
    end
    id_ready = 1'b1;
    cyc();
    chk("resume_pc", pc, 32'h10);
    chk("resume_addr", imem_addr, 32'h10);
    chk("resume_cnt", fetch_count, 32'd4);

    // Redirect in first REQ cycle, ack arrives 3 cycles later
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("drain_req", {31'd0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr, 32'h10);
      chk("drain_valid", {31'd0, instr_valid}, 32'd0);
      cyc();
    end
    chk("drain_addr2", imem_addr, 32'h10);
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    chk("drain_out_valid", {31'd0, instr_valid}, 32'd0);
    chk("drain_out_addr", imem_addr, 32'h100);
    chk("drain_out_err", {31'd0, addr_err}, 32'd0);

    // Misaligned redirect while a request is outstanding
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h202;
    cyc();
    redirect = 1'b0;
    chk("mis_err1", {31'd0, addr_err}, 32'd1);
    chk("mis_addr_hold", imem_addr, 32'h100);
    imem_ack = 1'b1;
    cyc();
    chk("mis_err0", {31'd0, addr_err}, 32'd0);
    chk("mis_addr_exc", imem_addr, 32'h80);

    // Redirect in the same cycle as ack: data dropped
    redirect    = 1'b1;
    redirect_pc = 32'h300;
    imem_rdata  = 32'hDEAD_0080;
    cyc();
    redirect = 1'b0;
    chk("same_valid", {31'd0, instr_valid}, 32'd0);
    chk("same_addr", imem_addr, 32'h300);
    chk("same_req", {31'd0, imem_req}, 32'd1);
    id_ready   = 1'b0;
    imem_rdata = 32'hC000_0300;
    cyc();
    chk("same_next_ipc", instr_pc, 32'h300);
    chk("same_next_instr", instr, 32'hC000_0300);
    chk("same_next_pc", pc, 32'h304);

    // Redirect in VALID with ready high still counts the handshake
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    id_ready    = 1'b1;
    imem_ack    = 1'b0;
    cyc();
    redirect = 1'b0;
    chk("vred_valid", {31'd0, instr_valid}, 32'd0);
    chk("vred_addr", imem_addr, 32'h40);
    chk("vred_cnt", fetch_count, 32'd5);

    // Enter DRAIN then reset asynchronously mid-cycle
    redirect    = 1'b1;
    redirect_pc = 32'h500;
    cyc();
    redirect = 1'b0;
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    chk("pre_rst_addr", imem_addr, 32'h40);
    #2;
    rst_n    = 1'b0;
    imem_ack = 1'b1;
    #1;
    chk_reset("arst");
    cyc();
    rst_n    = 1'b0;
    cyc();
    rst_n    = 1'b1;
    id_ready = 1'b0;
    chk("arst_idle_req", {31'd0, imem_req}, 32'd0);
    imem_rdata = 32'hE000_0000;
    cyc();
    chk("arst_first_addr", imem_addr, 32'h0);
    chk("arst_first_req", {31'd0, imem_req}, 32'd1);
    cyc();
    chk("arst_first_ipc", instr_pc, 32'h0);
    chk("arst_first_instr", instr, 32'hE000_0000);

    // PC increment wraps at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    imem_ack    = 1'b0;
    cyc();
    redirect = 1'b0;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_cnt", fetch_count, 32'd0);
    imem_ack = 1'b1;
    cyc();
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
